bird_anim: RTL and testbench

Animation and end-of-round sequencer that sits directly downstream of the game control block on the same 100 ms tick. It consumes the control block's `status`, `bird_y`, `pipe1` and `score` outputs. It produces:
- the bird sprite's wing frame and tilt,
- a game-over flag and a death flash,
- a persistent best score with a new-record flag.

The renderer reads all of these outputs directly as registered values.

---
 rtl/flappy_pkg.sv | 85 ++++++++
 rtl/best_score_reg.sv | 50 +++++
 rtl/bird_anim.sv | 181 ++++++++++++++++++
 tb/tb_bird_anim.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game blocks.
// Holds the sequencer state enum, default timing constants, tilt encodings,
// field layouts of the pipe1 / bird_y buses and small frame/tilt helpers.
package flappy_pkg;

  localparam int unsigned FALL_DIV_DEF    = 3;
  localparam int unsigned DYING_TICKS_DEF = 8;
  localparam int unsigned STALL_TICKS_DEF = 2;

  localparam int unsigned SCORE_W = 16;
  localparam int unsigned PIPE_W  = 10;
  localparam int unsigned FALL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Tilt encodings, nose up through nose down.
  localparam logic [1:0] TILT_UP     = 2'd0;
  localparam logic [1:0] TILT_SLIGHT = 2'd1;
  localparam logic [1:0] TILT_DOWN   = 2'd2;
  localparam logic [1:0] TILT_DIVE   = 2'd3;

  // pipe1 layout: gap at 27:20, x at 19:10, y at 9:0.
  typedef struct packed {
    logic [3:0]        rsvd;
    logic [7:0]        gap;
    logic [PIPE_W-1:0] x;
    logic [PIPE_W-1:0] y;
  } pipe_t;

  // bird_y layout: bit 15 rising flag, 14:0 vertical position.
  typedef struct packed {
    logic        rising;
    logic [14:0] y;
  } bird_y_t;

  // Wing frame index plus direction of travel through 0,1,2,1,0...
  typedef struct packed {
    logic       up;
    logic [1:0] idx;
  } frame_t;

  localparam frame_t FRAME_RST = '{up: 1'b1, idx: 2'd0};

  // Next wing frame in the ping-pong sequence.
  function automatic frame_t frame_next(input frame_t cur);
    frame_t nxt;
    nxt = cur;
    case (cur.idx)
      2'd0: begin
        nxt.idx = 2'd1;
        nxt.up  = 1'b1;
      end
      2'd1: nxt.idx = cur.up ? 2'd2 : 2'd0;
      default: begin
        nxt.idx = 2'd1;
        nxt.up  = 1'b0;
      end
    endcase
    return nxt;
  endfunction

  // Tilt while falling, from the number of ticks already spent falling.
  function automatic logic [1:0] tilt_from_fall(input logic [FALL_W-1:0] fall_cnt);
    logic [1:0] t;
    if (fall_cnt <= FALL_W'(1)) begin
      t = TILT_SLIGHT;
    end else if (fall_cnt <= FALL_W'(4)) begin
      t = TILT_DOWN;
    end else begin
      t = TILT_DIVE;
    end
    return t;
  endfunction

  // Control status codes 0 and 3 mean a round is in progress.
  function automatic logic round_running(input logic [1:0] status);
    return (status == 2'd0) || (status == 2'd3);
  endfunction

endpackage

// File: rtl/best_score_reg.sv
// Persistent best-score register with new-record flag.
// Ports: clk_100ms tick clock; rst sync active-low (clears new_best only);
// clr_best clears both outputs and beats everything else; capture pulses on
// the edge a round is lost, comparing score against the stored best.
module best_score_reg
  import flappy_pkg::*;
(
  input  logic               clk_100ms,
  input  logic               rst,
  input  logic               clr_best,
  input  logic               capture,
  input  logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score,
  output logic               new_best
);

  // Power-up value; rst intentionally leaves the best score alone.
  logic [SCORE_W-1:0] best_q = '0;
  logic [SCORE_W-1:0] best_d;
  logic               new_best_q;
  logic               new_best_d;

  // Clear beats reset, reset beats capture; equal score is not a record.
  always_comb begin
    best_d     = best_q;
    new_best_d = new_best_q;
    if (clr_best) begin
      best_d     = '0;
      new_best_d = 1'b0;
    end else if (!rst) begin
      new_best_d = 1'b0;
    end else if (capture) begin
      if (score > best_q) begin
        best_d     = score;
        new_best_d = 1'b1;
      end else begin
        new_best_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_100ms) begin
    best_q     <= best_d;
    new_best_q <= new_best_d;
  end

  assign best_score = best_q;
  assign new_best   = new_best_q;

endmodule

// File: rtl/bird_anim.sv
// Bird animation and end-of-round sequencer on the 100 ms game tick.
// Ports: clk_100ms, rst (sync active-low), clr_best; inputs status, bird_y,
// pipe1, score from the control block; registered outputs frame, tilt, dead,
// flash, best_score, new_best for the renderer.
module bird_anim
  import flappy_pkg::*;
#(
  parameter int unsigned FALL_DIV    = FALL_DIV_DEF,
  parameter int unsigned DYING_TICKS = DYING_TICKS_DEF,
  parameter int unsigned STALL_TICKS = STALL_TICKS_DEF
) (
  input  logic               clk_100ms,
  input  logic               rst,
  input  logic               clr_best,
  input  logic [1:0]         status,
  input  logic [15:0]        bird_y,
  input  logic [31:0]        pipe1,
  input  logic [SCORE_W-1:0] score,
  output logic [1:0]         frame,
  output logic [1:0]         tilt,
  output logic               dead,
  output logic               flash,
  output logic [SCORE_W-1:0] best_score,
  output logic               new_best
);

  localparam int unsigned DIV_W   = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
  localparam int unsigned STALL_W = $clog2(STALL_TICKS + 1);
  localparam int unsigned DYING_W = (DYING_TICKS > 1) ? $clog2(DYING_TICKS) : 1;

  pipe_t   pipe_s;
  bird_y_t bird_s;
  logic [PIPE_W-1:0] pipe_x;

  assign pipe_s = pipe_t'(pipe1);
  assign bird_s = bird_y_t'(bird_y);
  assign pipe_x = pipe_s.x;

  // Bus fields this block does not consume.
  logic unused_bits_c;
  assign unused_bits_c = ^{bird_s.y, pipe_s.rsvd, pipe_s.gap, pipe_s.y};

  state_e              state_q, state_d;
  frame_t              frame_q, frame_d;
  logic [1:0]          tilt_q, tilt_d;
  logic                dead_q, dead_d;
  logic                flash_q, flash_d;
  logic [FALL_W-1:0]   fall_cnt_q, fall_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [DYING_W-1:0]  dying_cnt_q, dying_cnt_d;
  logic [PIPE_W-1:0]   prev_x_q, prev_x_d;
  logic                dying_entry_c;

  // State register and animation flops.
  always_ff @(posedge clk_100ms) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      frame_q     <= FRAME_RST;
      tilt_q      <= TILT_UP;
      dead_q      <= 1'b0;
      flash_q     <= 1'b0;
      fall_cnt_q  <= '0;
      div_cnt_q   <= '0;
      stall_cnt_q <= '0;
      dying_cnt_q <= '0;
      prev_x_q    <= pipe_x;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      tilt_q      <= tilt_d;
      dead_q      <= dead_d;
      flash_q     <= flash_d;
      fall_cnt_q  <= fall_cnt_d;
      div_cnt_q   <= div_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      dying_cnt_q <= dying_cnt_d;
      prev_x_q    <= prev_x_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    tilt_d        = tilt_q;
    dead_d        = dead_q;
    flash_d       = flash_q;
    fall_cnt_d    = fall_cnt_q;
    div_cnt_d     = div_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    dying_cnt_d   = dying_cnt_q;
    prev_x_d      = pipe_x;
    dying_entry_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        frame_d     = FRAME_RST;
        tilt_d      = TILT_UP;
        dead_d      = 1'b0;
        flash_d     = 1'b0;
        fall_cnt_d  = '0;
        div_cnt_d   = '0;
        stall_cnt_d = '0;
        dying_cnt_d = '0;
        if (round_running(status)) begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (bird_s.rising) begin
          frame_d    = frame_next(frame_q);
          fall_cnt_d = '0;
          div_cnt_d  = '0;
          tilt_d     = TILT_UP;
        end else begin
          // Tilt follows the fall count sampled before this tick's increment.
          tilt_d     = tilt_from_fall(fall_cnt_q);
          fall_cnt_d = (fall_cnt_q == '1) ? fall_cnt_q : fall_cnt_q + FALL_W'(1);
          if (div_cnt_q >= DIV_W'(FALL_DIV - 1)) begin
            div_cnt_d = '0;
            frame_d   = frame_next(frame_q);
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end

        // A pipe that stops scrolling means the bird hit something.
        if (pipe_x == prev_x_q) begin
          stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end else begin
          stall_cnt_d = '0;
        end

        if (stall_cnt_d == STALL_W'(STALL_TICKS)) begin
          state_d       = ST_DYING;
          dying_entry_c = 1'b1;
          dead_d        = 1'b1;
          tilt_d        = TILT_DIVE;
          frame_d       = frame_q;
          flash_d       = 1'b1;
          dying_cnt_d   = '0;
          stall_cnt_d   = '0;
        end
      end

      ST_DYING: begin
        if (dying_cnt_q == DYING_W'(DYING_TICKS - 1)) begin
          state_d = ST_OVER;
          flash_d = 1'b0;
        end else begin
          flash_d     = ~flash_q;
          dying_cnt_d = dying_cnt_q + DYING_W'(1);
        end
      end

      ST_OVER: begin
        flash_d = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  best_score_reg u_best_score_reg (
    .clk_100ms  (clk_100ms),
    .rst        (rst),
    .clr_best   (clr_best),
    .capture    (dying_entry_c),
    .score      (score),
    .best_score (best_score),
    .new_best   (new_best)
  );

  assign frame = frame_q.idx;
  assign tilt  = tilt_q;
  assign dead  = dead_q;
  assign flash = flash_q;

endmodule

// File: tb/tb_bird_anim.sv
// Directed self-checking bench for bird_anim.
module tb_bird_anim;

  logic        clk_100ms;
  logic        rst;
  logic        clr_best;
  logic [1:0]  status;
  logic [15:0] bird_y;
  logic [31:0] pipe1;
  logic [15:0] score;
  logic [1:0]  frame;
  logic [1:0]  tilt;
  logic        dead;
  logic        flash;
  logic [15:0] best_score;
  logic        new_best;

  logic [9:0]  px;
  int          n_cmp;
  int          n_bad;

  bird_anim dut (
    .clk_100ms  (clk_100ms),
    .rst        (rst),
    .clr_best   (clr_best),
    .status     (status),
    .bird_y     (bird_y),
    .pipe1      (pipe1),
    .score      (score),
    .frame      (frame),
    .tilt       (tilt),
    .dead       (dead),
    .flash      (flash),
    .best_score (best_score),
    .new_best   (new_best)
  );

  initial clk_100ms = 1'b0;
  always #5 clk_100ms = ~clk_100ms;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_pipe();
    pipe1 = {4'h0, 8'd40, px, 10'd200};
  endtask

  task automatic tick();
    @(posedge clk_100ms);
    #1;
  endtask

  // Scroll the pipe one pixel, then advance one tick.
  task automatic tick_move();
    px = px - 10'd1;
    drive_pipe();
    tick();
  endtask

  // Start a round, optionally stall one tick short of death, then freeze the
  // pipe at x=120 until the loss is declared on the third frozen tick.
  task automatic play_round(input logic [15:0] sc, input logic clr, input logic near);
    rst    = 1'b1;
    status = 2'd0;
    bird_y = 16'h00F0;
    score  = sc;
    repeat (4) tick_move();
    if (near) begin
      tick();
      chk("near_hold_dead", 32'(dead), 32'd0);
      tick_move();
      chk("near_move_dead", 32'(dead), 32'd0);
    end
    px = 10'd120;
    drive_pipe();
    tick();
    chk("rnd_z1_dead", 32'(dead), 32'd0);
    tick();
    chk("rnd_z2_dead", 32'(dead), 32'd0);
    clr_best = clr;
    tick();
    clr_best = 1'b0;
    chk("rnd_z3_dead", 32'(dead), 32'd1);
  endtask

  task automatic reset_tick();
    rst    = 1'b0;
    status = 2'd1;
    tick();
  endtask

  logic [1:0] exp_rise  [5] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0};
  logic [1:0] exp_ftilt [7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
  logic [1:0] exp_fframe[7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
  logic       exp_flash [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b0;
    clr_best = 1'b0;
    status   = 2'd1;
    bird_y   = 16'h80F0;
    score    = 16'd0;
    px       = 10'd600;
    drive_pipe();

    repeat (3) tick();
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_tilt", 32'(tilt), 32'd0);
    chk("rst_dead", 32'(dead), 32'd0);
    chk("rst_flash", 32'(flash), 32'd0);
    chk("rst_new_best", 32'(new_best), 32'd0);
    chk("pwrup_best", 32'(best_score), 32'd0);

    // Round 1: rising, then falling, then the pipe freezes.
    rst    = 1'b1;
    status = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick_move();
      chk($sformatf("rise_frame%0d", i), 32'(frame), 32'(exp_rise[i]));
      chk($sformatf("rise_tilt%0d", i), 32'(tilt), 32'd0);
    end
    bird_y = 16'h00F0;
    for (int i = 0; i < 7; i++) begin
      tick_move();
      chk($sformatf("fall_tilt%0d", i), 32'(tilt), 32'(exp_ftilt[i]));
      chk($sformatf("fall_frame%0d", i), 32'(frame), 32'(exp_fframe[i]));
    end

    score = 16'd5;
    px    = 10'd120;
    drive_pipe();
    tick();
    chk("z1_dead", 32'(dead), 32'd0);
    chk("z1_frame", 32'(frame), 32'd2);
    tick();
    chk("z2_dead", 32'(dead), 32'd0);
    chk("z2_frame", 32'(frame), 32'd1);
    tick();
    chk("z3_dead", 32'(dead), 32'd1);
    chk("z3_tilt", 32'(tilt), 32'd3);
    chk("z3_frame", 32'(frame), 32'd1);
    chk("z3_best", 32'(best_score), 32'd5);
    chk("z3_new_best", 32'(new_best), 32'd1);
    chk("flash0", 32'(flash), 32'(exp_flash[0]));
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("flash%0d", i), 32'(flash), 32'(exp_flash[i]));
      chk($sformatf("dying_frame%0d", i), 32'(frame), 32'd1);
    end
    tick();
    chk("over_flash", 32'(flash), 32'd0);
    chk("over_dead", 32'(dead), 32'd1);
    chk("over_tilt", 32'(tilt), 32'd3);
    status = 2'd1;
    tick();
    chk("over_status_dead", 32'(dead), 32'd1);
    chk("over_status_flash", 32'(flash), 32'd0);

    reset_tick();
    chk("r1_rst_dead", 32'(dead), 32'd0);
    chk("r1_rst_new_best", 32'(new_best), 32'd0);
    chk("r1_rst_best", 32'(best_score), 32'd5);

    // Round 2: tie with the record.
    play_round(16'd5, 1'b0, 1'b0);
    chk("r2_best", 32'(best_score), 32'd5);
    chk("r2_new_best", 32'(new_best), 32'd0);
    repeat (8) tick();
    reset_tick();

    // Round 3: new record, with a one-tick stall that must not kill.
    play_round(16'd9, 1'b0, 1'b1);
    chk("r3_best", 32'(best_score), 32'd9);
    chk("r3_new_best", 32'(new_best), 32'd1);
    repeat (8) tick();
    reset_tick();

    // Round 4: clear coincides with the loss.
    play_round(16'd12, 1'b1, 1'b0);
    chk("r4_best", 32'(best_score), 32'd0);
    chk("r4_new_best", 32'(new_best), 32'd0);
    chk("r4_dead", 32'(dead), 32'd1);
    repeat (8) tick();
    reset_tick();

    // Round 5: reset in the middle of the flash sequence.
    play_round(16'd3, 1'b0, 1'b0);
    chk("r5_best", 32'(best_score), 32'd3);
    chk("r5_new_best", 32'(new_best), 32'd1);
    repeat (2) tick();
    chk("r5_mid_flash", 32'(flash), 32'd1);
    reset_tick();
    chk("mid_rst_dead", 32'(dead), 32'd0);
    chk("mid_rst_flash", 32'(flash), 32'd0);
    chk("mid_rst_frame", 32'(frame), 32'd0);
    chk("mid_rst_tilt", 32'(tilt), 32'd0);
    chk("mid_rst_new_best", 32'(new_best), 32'd0);
    chk("mid_rst_best", 32'(best_score), 32'd3);

    clr_best = 1'b1;
    tick();
    clr_best = 1'b0;
    chk("clr_in_rst_best", 32'(best_score), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
